// File: rtl/us_echo_delay_meter_if.sv
// Measurement trigger/echo inputs and committed-result outputs of the ultrasound
// time-of-flight meter, bundled for the meter (slave) and its driver (master).
interface us_echo_delay_meter_if;
  logic        start;
  logic        abort;
  logic        echo;
  logic [31:0] delay;
  logic        valid;
  logic        busy;
  logic        timeout;

  modport master (output start, abort, echo, input delay, valid, busy, timeout);
  modport slave  (input start, abort, echo, output delay, valid, busy, timeout);
endinterface

// File: rtl/us_echo_delay_meter.sv
// Ultrasound time-of-flight meter: counts clk cycles from an accepted start to the first
// echo that stays high for MIN_PULSE synced cycles, and holds the result for PIO reads.
module us_echo_delay_meter #(
  parameter int SYNC_STAGES    = 2,
  parameter int BLANK_CYCLES   = 1000,
  parameter int MIN_PULSE      = 4,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  us_echo_delay_meter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BLANK  = 2'd1,
    LISTEN = 2'd2
  } state_t;

  localparam int              RUN_W        = $clog2(MIN_PULSE + 1);
  localparam logic [RUN_W-1:0] RUN_MAX      = RUN_W'(MIN_PULSE);
  localparam logic [RUN_W-1:0] RUN_ONE      = RUN_W'(1);
  localparam logic [31:0]      BLANK_LAST   = 32'(BLANK_CYCLES - 1);
  localparam logic [31:0]      TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t                 state_r, state_nx_s;
  logic [31:0]            cnt_r, cnt_nx_s;
  logic [31:0]            cand_r, cand_nx_s;
  logic [RUN_W-1:0]       run_r, run_nx_s;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   echo_prev_r;
  logic [31:0]            delay_r, delay_nx_s;
  logic                   valid_r, valid_nx_s;
  logic                   busy_r;
  logic                   timeout_r, timeout_nx_s;
  logic                   echo_s;
  logic                   rise_s;

  assign echo_s = sync_r[SYNC_STAGES-1];
  // echo_prev_r is zero on the first LISTEN cycle, so an echo already high counts as an edge
  assign rise_s = echo_s & ~echo_prev_r;

  // Echo synchronizer and LISTEN-only edge history
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r      <= '0;
      echo_prev_r <= 1'b0;
    end else begin
      sync_r      <= {sync_r[SYNC_STAGES-2:0], bus.echo};
      echo_prev_r <= (state_r == LISTEN) ? echo_s : 1'b0;
    end
  end

  // Next-state, counter and commit decisions
  always_comb begin
    state_nx_s   = state_r;
    cnt_nx_s     = cnt_r;
    cand_nx_s    = cand_r;
    run_nx_s     = run_r;
    delay_nx_s   = delay_r;
    valid_nx_s   = 1'b0;
    timeout_nx_s = timeout_r;
    case (state_r)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_nx_s   = BLANK;
          cnt_nx_s     = 32'd0;
          run_nx_s     = '0;
          timeout_nx_s = 1'b0;
        end else begin
          state_nx_s   = IDLE;
        end
      end
      BLANK: begin
        cnt_nx_s = cnt_r + 32'd1;
        run_nx_s = '0;
        if (bus.abort) begin
          state_nx_s = IDLE;
        end else if (cnt_r == BLANK_LAST) begin
          state_nx_s = LISTEN;
        end else begin
          state_nx_s = BLANK;
        end
      end
      LISTEN: begin
        cnt_nx_s = cnt_r + 32'd1;
        if (echo_s) begin
          if (rise_s) begin
            run_nx_s  = RUN_ONE;
            cand_nx_s = cnt_r;
          end else if (run_r != RUN_MAX) begin
            run_nx_s  = run_r + RUN_ONE;
          end else begin
            run_nx_s  = run_r;
          end
        end else begin
          run_nx_s = '0;
        end
        if (bus.abort) begin
          state_nx_s = IDLE;
        end else if (echo_s && (run_nx_s == RUN_MAX)) begin
          state_nx_s = IDLE;
          delay_nx_s = rise_s ? cnt_r : cand_r;
          valid_nx_s = 1'b1;
        end else if (cnt_r == TIMEOUT_LAST) begin
          state_nx_s   = IDLE;
          delay_nx_s   = 32'hFFFF_FFFF;
          valid_nx_s   = 1'b1;
          timeout_nx_s = 1'b1;
        end else begin
          state_nx_s = LISTEN;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State, measurement registers and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      cnt_r     <= 32'd0;
      cand_r    <= 32'd0;
      run_r     <= '0;
      delay_r   <= 32'd0;
      valid_r   <= 1'b0;
      busy_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      cnt_r     <= cnt_nx_s;
      cand_r    <= cand_nx_s;
      run_r     <= run_nx_s;
      delay_r   <= delay_nx_s;
      valid_r   <= valid_nx_s;
      busy_r    <= (state_nx_s != IDLE);
      timeout_r <= timeout_nx_s;
    end
  end

  assign bus.delay   = delay_r;
  assign bus.valid   = valid_r;
  assign bus.busy    = busy_r;
  assign bus.timeout = timeout_r;

endmodule
